// File: rtl/video_sync_gen.sv
// Raster timing generator: pixel-strobe divider, h/v counters and registered sync/blanking outputs.
// Optional start-of-vblank interrupt (frame_irq/irq_ack) is built only when VSYNC_IRQ_EN is defined.
module video_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 160,
  parameter int H_FRONT   = 8,
  parameter int H_SYNC    = 16,
  parameter int H_BACK    = 16,
  parameter int V_DISPLAY = 120,
  parameter int V_FRONT   = 2,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 4,
  parameter int SYNC_POL  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef VSYNC_IRQ_EN
  input  logic       irq_ack,
  output logic       frame_irq,
`endif
  output logic       pix_ce,
  output logic [7:0] hpos,
  output logic [6:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (CLK_DIV < 1 || H_TOTAL > 256 || V_TOTAL > 128) begin : g_bad_params
    $error("video_sync_gen: illegal divider or timing parameters");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // 9/8-bit bounds so that sums reaching exactly 256/128 still compare correctly.
  localparam logic [7:0] H_LAST   = 8'(H_TOTAL - 1);
  localparam logic [6:0] V_LAST   = 7'(V_TOTAL - 1);
  localparam logic [8:0] H_DISP9  = 9'(H_DISPLAY);
  localparam logic [8:0] HS_START = 9'(H_DISPLAY + H_FRONT);
  localparam logic [8:0] HS_END   = 9'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [7:0] V_DISP8  = 8'(V_DISPLAY);
  localparam logic [7:0] VS_START = 8'(V_DISPLAY + V_FRONT);
  localparam logic [7:0] VS_END   = 8'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_ce;
  logic [7:0]       r_hpos;
  logic [6:0]       r_vpos;
  logic             r_hs_act;
  logic             r_vs_act;
  logic             r_display_on;

  logic             w_tick;
  logic [7:0]       w_hpos_nxt;
  logic [6:0]       w_vpos_nxt;
  logic             w_hs_nxt;
  logic             w_vs_nxt;
  logic             w_de_nxt;

  assign w_tick = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div    <= '0;
      r_pix_ce <= 1'b0;
    end else begin
      r_div    <= w_tick ? '0 : r_div + 1'b1;
      r_pix_ce <= w_tick;
    end
  end

  always_comb begin
    w_hpos_nxt = r_hpos;
    w_vpos_nxt = r_vpos;
    if (w_tick) begin
      if (r_hpos == H_LAST) begin
        w_hpos_nxt = '0;
        w_vpos_nxt = (r_vpos == V_LAST) ? '0 : r_vpos + 7'd1;
      end else begin
        w_hpos_nxt = r_hpos + 8'd1;
      end
    end
  end

  // Decoding the next-state counters keeps sync/blanking aligned with hpos/vpos on the same edge.
  always_comb begin
    w_hs_nxt = ({1'b0, w_hpos_nxt} >= HS_START) && ({1'b0, w_hpos_nxt} < HS_END);
    w_vs_nxt = ({1'b0, w_vpos_nxt} >= VS_START) && ({1'b0, w_vpos_nxt} < VS_END);
    w_de_nxt = ({1'b0, w_hpos_nxt} < H_DISP9) && ({1'b0, w_vpos_nxt} < V_DISP8);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hpos       <= '0;
      r_vpos       <= '0;
      r_hs_act     <= 1'b0;
      r_vs_act     <= 1'b0;
      r_display_on <= 1'b1;
    end else begin
      r_hpos       <= w_hpos_nxt;
      r_vpos       <= w_vpos_nxt;
      r_hs_act     <= w_hs_nxt;
      r_vs_act     <= w_vs_nxt;
      r_display_on <= w_de_nxt;
    end
  end

  assign pix_ce     = r_pix_ce;
  assign hpos       = r_hpos;
  assign vpos       = r_vpos;
  assign hsync      = (SYNC_POL != 0) ? r_hs_act : ~r_hs_act;
  assign vsync      = (SYNC_POL != 0) ? r_vs_act : ~r_vs_act;
  assign display_on = r_display_on;

`ifdef VSYNC_IRQ_EN
  logic r_frame_irq;
  logic w_irq_set;

  // A new set on the acknowledging clock wins so a fresh vblank is never lost.
  assign w_irq_set = w_tick && (w_hpos_nxt == 8'd0) && ({1'b0, w_vpos_nxt} == V_DISP8);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_irq <= 1'b0;
    end else if (w_irq_set) begin
      r_frame_irq <= 1'b1;
    end else if (irq_ack) begin
      r_frame_irq <= 1'b0;
    end
  end

  assign frame_irq = r_frame_irq;
`endif

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: default-timing instance (CLK_DIV=4, active-high sync) and a fast
// instance (CLK_DIV=1, active-low sync) for full-frame, vsync and interrupt behaviour.
module tb_video_sync_gen;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  always #5 clk = ~clk;

  logic       pix_ce_a, hsync_a, vsync_a, de_a;
  logic [7:0] hpos_a;
  logic [6:0] vpos_a;
  logic       pix_ce_b, hsync_b, vsync_b, de_b;
  logic [7:0] hpos_b;
  logic [6:0] vpos_b;
`ifdef VSYNC_IRQ_EN
  logic irq_ack_a = 1'b0;
  logic irq_ack_b = 1'b0;
  logic frame_irq_a, frame_irq_b;
`endif

  video_sync_gen u_dut_a (
    .clk        (clk),
    .reset_n    (rst_a_n),
`ifdef VSYNC_IRQ_EN
    .irq_ack    (irq_ack_a),
    .frame_irq  (frame_irq_a),
`endif
    .pix_ce     (pix_ce_a),
    .hpos       (hpos_a),
    .vpos       (vpos_a),
    .hsync      (hsync_a),
    .vsync      (vsync_a),
    .display_on (de_a)
  );

  video_sync_gen #(.CLK_DIV(1), .SYNC_POL(0)) u_dut_b (
    .clk        (clk),
    .reset_n    (rst_b_n),
`ifdef VSYNC_IRQ_EN
    .irq_ack    (irq_ack_b),
    .frame_irq  (frame_irq_b),
`endif
    .pix_ce     (pix_ce_b),
    .hpos       (hpos_b),
    .vpos       (vpos_b),
    .hsync      (hsync_b),
    .vsync      (vsync_b),
    .display_on (de_b)
  );

  // Expected raster point after the idx-th pix_ce since reset release, cyc clocks after release.
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] cyc;
    logic [7:0]  h;
    logic [6:0]  v;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  exp_t exp_a_q[$];
  exp_t exp_b_q[$];

  int errors = 0;
  int checks = 0;
  int unsigned cnt_a = 0, cyc_a = 0, cnt_b = 0, cyc_b = 0;
  int vs_clks_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input bit sel_b, input int unsigned idx, input int unsigned cyc,
                      input logic [7:0] h, input logic [6:0] v,
                      input logic hs, input logic vs, input logic de);
    exp_t e;
    e = '{idx: idx, cyc: cyc, h: h, v: v, hs: hs, vs: vs, de: de};
    if (sel_b) exp_b_q.push_back(e);
    else exp_a_q.push_back(e);
  endtask

  task automatic cmp_point(input string tag, input exp_t e, input int unsigned cyc,
                           input logic [7:0] h, input logic [6:0] v,
                           input logic hs, input logic vs, input logic de);
    chk($sformatf("%s_k%0d_cycle", tag, e.idx), cyc, e.cyc);
    chk($sformatf("%s_k%0d_hpos", tag, e.idx), {24'd0, h}, {24'd0, e.h});
    chk($sformatf("%s_k%0d_vpos", tag, e.idx), {25'd0, v}, {25'd0, e.v});
    chk($sformatf("%s_k%0d_hsync", tag, e.idx), {31'd0, hs}, {31'd0, e.hs});
    chk($sformatf("%s_k%0d_vsync", tag, e.idx), {31'd0, vs}, {31'd0, e.vs});
    chk($sformatf("%s_k%0d_display_on", tag, e.idx), {31'd0, de}, {31'd0, e.de});
  endtask

  // Monitors: count clocks and pix_ce strobes since release, pop and compare at each checkpoint.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_a_n) begin
      cnt_a = 0;
      cyc_a = 0;
    end else begin
      cyc_a = cyc_a + 1;
      if (pix_ce_a) begin
        cnt_a = cnt_a + 1;
        if (exp_a_q.size() > 0 && exp_a_q[0].idx == cnt_a) begin
          e = exp_a_q.pop_front();
          cmp_point("a", e, cyc_a, hpos_a, vpos_a, hsync_a, vsync_a, de_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_b_n) begin
      cnt_b = 0;
      cyc_b = 0;
    end else begin
      cyc_b = cyc_b + 1;
      if (pix_ce_b) begin
        cnt_b = cnt_b + 1;
        if (exp_b_q.size() > 0 && exp_b_q[0].idx == cnt_b) begin
          e = exp_b_q.pop_front();
          cmp_point("b", e, cyc_b, hpos_b, vpos_b, hsync_b, vsync_b, de_b);
        end
      end
    end
  end

  task automatic wait_cnt_a(input int unsigned target, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (cnt_a >= target) begin ok = 1'b1; break; end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic step_b();
    @(negedge clk); #1;
    if (vsync_b == 1'b0) vs_clks_b++;
  endtask

  task automatic run_b_until(input int unsigned target, input int budget, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_b();
      if (cnt_b >= target) begin ok = 1'b1; break; end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic run_a();
    int hs_clks;
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk("a_rst_pix_ce", {31'd0, pix_ce_a}, 32'd0);
    chk("a_rst_hpos", {24'd0, hpos_a}, 32'd0);
    chk("a_rst_vpos", {25'd0, vpos_a}, 32'd0);
    chk("a_rst_hsync", {31'd0, hsync_a}, 32'd0);
    chk("a_rst_vsync", {31'd0, vsync_a}, 32'd0);
    chk("a_rst_display_on", {31'd0, de_a}, 32'd1);
    push(0, 1, 4, 8'd1, 7'd0, 0, 0, 1);
    push(0, 159, 636, 8'd159, 7'd0, 0, 0, 1);
    push(0, 160, 640, 8'd160, 7'd0, 0, 0, 0);
    push(0, 167, 668, 8'd167, 7'd0, 0, 0, 0);
    push(0, 168, 672, 8'd168, 7'd0, 1, 0, 0);
    push(0, 183, 732, 8'd183, 7'd0, 1, 0, 0);
    push(0, 184, 736, 8'd184, 7'd0, 0, 0, 0);
    push(0, 199, 796, 8'd199, 7'd0, 0, 0, 0);
    push(0, 200, 800, 8'd0, 7'd1, 0, 0, 1);
    push(0, 201, 804, 8'd1, 7'd1, 0, 0, 1);
    push(0, 10077, 40308, 8'd77, 7'd50, 0, 0, 1);
    @(negedge clk); #2 rst_a_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("a_first_pix_ce_clk%0d", i), {31'd0, pix_ce_a}, (i == 4) ? 32'd1 : 32'd0);
    end
    chk("a_first_hpos", {24'd0, hpos_a}, 32'd1);
    hs_clks = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (hsync_a) hs_clks++;
      if (cnt_a >= 200) begin ok = 1'b1; break; end
    end
    chk("a_wait_line0", {31'd0, ok}, 32'd1);
    chk("a_hsync_clocks", hs_clks, 32'd64);
    wait_cnt_a(10077, 45000, "a_wait_77_50");
    #1 rst_a_n = 1'b0;
    #1;
    chk("a_async_rst_pix_ce", {31'd0, pix_ce_a}, 32'd0);
    chk("a_async_rst_hpos", {24'd0, hpos_a}, 32'd0);
    chk("a_async_rst_vpos", {25'd0, vpos_a}, 32'd0);
    chk("a_async_rst_hsync", {31'd0, hsync_a}, 32'd0);
    chk("a_async_rst_display_on", {31'd0, de_a}, 32'd1);
    @(negedge clk); #2 rst_a_n = 1'b1;
    push(0, 1, 4, 8'd1, 7'd0, 0, 0, 1);
    push(0, 200, 800, 8'd0, 7'd1, 0, 0, 1);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (exp_a_q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("a_wait_restart", {31'd0, ok}, 32'd1);
  endtask

  task automatic run_b();
    repeat (3) @(posedge clk);
    #1;
    chk("b_rst_pix_ce", {31'd0, pix_ce_b}, 32'd0);
    chk("b_rst_hsync_low_pol", {31'd0, hsync_b}, 32'd1);
    chk("b_rst_vsync_low_pol", {31'd0, vsync_b}, 32'd1);
    chk("b_rst_display_on", {31'd0, de_b}, 32'd1);
`ifdef VSYNC_IRQ_EN
    chk("b_rst_frame_irq", {31'd0, frame_irq_b}, 32'd0);
`endif
    push(1, 1, 1, 8'd1, 7'd0, 1, 1, 1);
    push(1, 23959, 23959, 8'd159, 7'd119, 1, 1, 1);
    push(1, 23960, 23960, 8'd160, 7'd119, 1, 1, 0);
    push(1, 23999, 23999, 8'd199, 7'd119, 1, 1, 0);
    push(1, 24000, 24000, 8'd0, 7'd120, 1, 1, 0);
    push(1, 24368, 24368, 8'd168, 7'd121, 0, 1, 0);
    push(1, 24399, 24399, 8'd199, 7'd121, 1, 1, 0);
    push(1, 24400, 24400, 8'd0, 7'd122, 1, 0, 0);
    push(1, 24600, 24600, 8'd0, 7'd123, 1, 0, 0);
    push(1, 24799, 24799, 8'd199, 7'd123, 1, 0, 0);
    push(1, 24800, 24800, 8'd0, 7'd124, 1, 1, 0);
    push(1, 25599, 25599, 8'd199, 7'd127, 1, 1, 0);
    push(1, 25600, 25600, 8'd0, 7'd0, 1, 1, 1);
    push(1, 25601, 25601, 8'd1, 7'd0, 1, 1, 1);
    @(negedge clk); #2 rst_b_n = 1'b1;
    run_b_until(23999, 25000, "b_wait_pre_vblank");
`ifdef VSYNC_IRQ_EN
    chk("b_irq_before_vblank", {31'd0, frame_irq_b}, 32'd0);
    step_b();
    chk("b_irq_rise", {31'd0, frame_irq_b}, 32'd1);
    #1 irq_ack_b = 1'b1;
    step_b();
    chk("b_irq_acked", {31'd0, frame_irq_b}, 32'd0);
    step_b();
    chk("b_irq_ack_while_clear", {31'd0, frame_irq_b}, 32'd0);
    #1 irq_ack_b = 1'b0;
`endif
    run_b_until(25601, 3000, "b_wait_frame_wrap");
    chk("b_vsync_active_clocks", vs_clks_b, 32'd400);
`ifdef VSYNC_IRQ_EN
    run_b_until(49599, 25000, "b_wait_next_vblank");
    chk("b_irq_still_clear", {31'd0, frame_irq_b}, 32'd0);
    #1 irq_ack_b = 1'b1;
    step_b();
    chk("b_irq_set_beats_ack", {31'd0, frame_irq_b}, 32'd1);
    #1 irq_ack_b = 1'b0;
    step_b();
    chk("b_irq_sticky", {31'd0, frame_irq_b}, 32'd1);
    #1 irq_ack_b = 1'b1;
    step_b();
    chk("b_irq_second_ack", {31'd0, frame_irq_b}, 32'd0);
    #1 irq_ack_b = 1'b0;
`endif
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    chk("a_queue_drained", exp_a_q.size(), 32'd0);
    chk("b_queue_drained", exp_b_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
